// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap instead of NOP.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] branchType,
  output logic [1:0] pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic       instrDone,
  output logic       memError,
`ifdef ILLEGAL_TRAP_EN
  output logic       trap,
`endif
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_I_EXEC    = 4'd8;
  localparam logic [3:0] S_I_WB      = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_ERROR     = 4'd11;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP      = 4'd12;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  localparam logic             TMO_EN = (MEM_TIMEOUT != 0);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [5:0]       r_opReg;
  logic [CNT_W-1:0] r_waitCnt;
  logic             r_memError;
  logic             w_tmo;

  assign w_tmo    = TMO_EN && !memReady && (r_waitCnt == TMO);
  assign state    = r_state;
  assign memError = r_memError;
`ifdef ILLEGAL_TRAP_EN
  assign trap     = (r_state == S_TRAP);
`endif

  // Next-state selection; memReady always beats the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (memReady)   w_next = S_DECODE;
        else if (w_tmo) w_next = S_ERROR;
      end
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW:               w_next = S_MEM_ADDR;
          OP_RTYPE:                   w_next = S_R_EXEC;
          OP_BEQ, OP_BNE, OP_BGTZ:    w_next = S_BRANCH;
          OP_ADDI, OP_SUBI, OP_ANDI,
          OP_ORI, OP_SLTI:            w_next = S_I_EXEC;
`ifdef ILLEGAL_TRAP_EN
          default:                    w_next = S_TRAP;
`else
          default:                    w_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:
        w_next = (r_opReg == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (memReady)   w_next = S_MEM_WB;
        else if (w_tmo) w_next = S_ERROR;
      end
      S_MEM_WB:  w_next = S_FETCH;
      S_MEM_WRITE: begin
        if (memReady)   w_next = S_FETCH;
        else if (w_tmo) w_next = S_ERROR;
      end
      S_R_EXEC:  w_next = S_R_WB;
      S_R_WB:    w_next = S_FETCH;
      S_I_EXEC:  w_next = S_I_WB;
      S_I_WB:    w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ERROR:   w_next = S_ERROR;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:    w_next = S_TRAP;
`endif
      default:   w_next = S_FETCH;
    endcase
  end

  // State, latched opcode, wait counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_opReg    <= '0;
      r_waitCnt  <= '0;
      r_memError <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_opReg <= op_code;
      if (w_next != r_state)
        r_waitCnt <= '0;
      else if (!memReady && r_waitCnt != TMO)
        r_waitCnt <= r_waitCnt + 1'b1;
      if (w_next == S_ERROR)
        r_memError <= 1'b1;
    end
  end

  // Datapath controls decoded from the registered state.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchType  = 2'b00;
    pcSource    = 2'b00;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 3'b000;
    instrDone   = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEM_WRITE: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
      end
      S_R_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 3'b010;
      end
      S_R_WB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        instrDone = 1'b1;
      end
      S_I_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        case (r_opReg)
          OP_SUBI: aluOp = 3'b001;
          OP_ANDI: aluOp = 3'b101;
          OP_ORI:  aluOp = 3'b011;
          OP_SLTI: aluOp = 3'b100;
          default: aluOp = 3'b000;
        endcase
      end
      S_I_WB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 3'b001;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instrDone   = 1'b1;
        case (r_opReg)
          OP_BNE:  branchType = 2'b01;
          OP_BGTZ: branchType = 2'b10;
          default: branchType = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM.
// Expected values are hand-derived from the state sequence of each opcode.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op_code;
  logic       memReady;
  logic       pcWrite;
  logic       pcWriteCond;
  logic [1:0] branchType;
  logic [1:0] pcSource;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluOp;
  logic       instrDone;
  logic       memError;
  logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
  logic       trap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .op_code(op_code),
    .memReady(memReady),
    .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond),
    .branchType(branchType),
    .pcSource(pcSource),
    .iorD(iorD),
    .memRead(memRead),
    .memWrite(memWrite),
    .irWrite(irWrite),
    .regDst(regDst),
    .memToReg(memToReg),
    .regWrite(regWrite),
    .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB),
    .aluOp(aluOp),
    .instrDone(instrDone),
    .memError(memError),
`ifdef ILLEGAL_TRAP_EN
    .trap(trap),
`endif
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH; op_code is scrambled after DECODE
  // so later states must rely on the latched opcode.
  task automatic run(input logic [5:0] op, output int len,
                     output logic [2:0] aop3, output logic [1:0] bt3,
                     output logic pwc3, output logic [1:0] ps3,
                     output logic rw3, output logic [3:0] fin);
    len  = 0;
    aop3 = 'x; bt3 = 'x; pwc3 = 'x; ps3 = 'x; rw3 = 'x; fin = 'x;
    op_code = op;
    for (int c = 1; c <= 40; c++) begin
      if (c >= 3) op_code = ~op;
      #1;
      if (c == 3) begin
        aop3 = aluOp; bt3 = branchType; pwc3 = pcWriteCond;
        ps3 = pcSource; rw3 = regWrite;
      end
      if (instrDone) begin
        len = c;
        fin = {regWrite, regDst, memToReg, memWrite};
        tick();
        break;
      end
      tick();
    end
  endtask

  int         len;
  logic [2:0] aop3;
  logic [1:0] bt3;
  logic       pwc3;
  logic [1:0] ps3;
  logic       rw3;
  logic [3:0] fin;

  initial begin
    reset    = 1'b1;
    op_code  = 6'b0;
    memReady = 1'b0;
    #2;
    chk("rst_state", state, 4'd0);
    chk("rst_memRead", memRead, 1);
    chk("rst_irWrite_lo", irWrite, 0);
    chk("rst_memError", memError, 0);
    chk("rst_aluSrcB", aluSrcB, 2'b01);
    memReady = 1'b1;
    #1;
    chk("fetch_irWrite", irWrite, 1);
    chk("fetch_pcWrite", pcWrite, 1);
    tick();
    reset = 1'b0;

    // add, lw, sw, beq, addi with zero-wait memory
    run(6'b000000, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("add_len", len, 4);
    chk("add_aluOp", aop3, 3'b010);
    chk("add_fin", fin, 4'b1100);
    run(6'b100011, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("lw_len", len, 5);
    chk("lw_aluOp", aop3, 3'b000);
    chk("lw_fin", fin, 4'b1010);
    run(6'b101011, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("sw_len", len, 4);
    chk("sw_fin", fin, 4'b0001);
    run(6'b000100, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("beq_len", len, 3);
    chk("beq_aluOp", aop3, 3'b001);
    chk("beq_bt", bt3, 2'b00);
    run(6'b001000, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("addi_len", len, 4);
    chk("addi_aluOp", aop3, 3'b000);

    // I-type ALU ops
    run(6'b001100, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("andi_aluOp", aop3, 3'b101);
    chk("andi_fin", fin, 4'b1000);
    run(6'b001101, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("ori_aluOp", aop3, 3'b011);
    run(6'b001010, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("slti_aluOp", aop3, 3'b100);
    run(6'b001001, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("subi_aluOp", aop3, 3'b001);
    chk("subi_len", len, 4);

    // bgtz and bne
    run(6'b000111, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("bgtz_len", len, 3);
    chk("bgtz_bt", bt3, 2'b10);
    chk("bgtz_pwc", pwc3, 1);
    chk("bgtz_ps", ps3, 2'b01);
    chk("bgtz_rw", rw3, 0);
    run(6'b000101, len, aop3, bt3, pwc3, ps3, rw3, fin);
    chk("bne_bt", bt3, 2'b01);

    // lw with three wait cycles in MEM_READ: 8 cycles total
    op_code = 6'b100011;
    chk("lww_c1", state, 4'd0);
    tick();
    chk("lww_c2", state, 4'd1);
    tick();
    chk("lww_c3", state, 4'd2);
    tick();
    for (int c = 4; c <= 7; c++) begin
      memReady = (c == 7);
      #1;
      chk($sformatf("lww_rd_c%0d", c), state, 4'd3);
      chk($sformatf("lww_strb_c%0d", c), {memRead, iorD}, 2'b11);
      tick();
    end
    chk("lww_c8_state", state, 4'd4);
    chk("lww_c8_done", instrDone, 1);
    chk("lww_memError", memError, 0);
    tick();

    // sw held 15 cycles low; memReady on the boundary count wins
    op_code = 6'b101011;
    memReady = 1'b1;
    tick();
    tick();
    tick();
    chk("swb_state", state, 4'd5);
    memReady = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk("swb_wait_done", instrDone, 0);
      tick();
    end
    memReady = 1'b1;
    #1;
    chk("swb_last_state", state, 4'd5);
    chk("swb_last_done", instrDone, 1);
    tick();
    chk("swb_back_fetch", state, 4'd0);
    chk("swb_memError", memError, 0);

    // FETCH timeout: 16 FETCH cycles then ERROR
    memReady = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk($sformatf("tmo_fetch_c%0d", c), state, 4'd0);
      tick();
    end
    chk("tmo_err_state", state, 4'd11);
    chk("tmo_memError", memError, 1);
    chk("tmo_memRead", memRead, 0);
    memReady = 1'b1;
    #1;
    chk("tmo_irWrite", irWrite, 0);
    tick();
    tick();
    chk("tmo_hold_state", state, 4'd11);
    chk("tmo_sticky", memError, 1);
    reset = 1'b1;
    #1;
    chk("tmo_rst_state", state, 4'd0);
    chk("tmo_rst_err", memError, 0);
    tick();
    reset = 1'b0;

    // unknown opcode
    op_code = 6'b111111;
    tick();
    chk("unk_decode", state, 4'd1);
    chk("unk_dec_rw", {regWrite, memWrite}, 2'b00);
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("unk_trap_state", state, 4'd12);
    chk("unk_trap", trap, 1);
    chk("unk_trap_strb", {regWrite, memWrite, memRead}, 3'b000);
    tick();
    chk("unk_trap_hold", trap, 1);
    reset = 1'b1;
    #1;
    chk("unk_trap_rst", trap, 0);
    tick();
    reset = 1'b0;
`else
    chk("unk_nop_fetch", state, 4'd0);
    chk("unk_nop_rw", {regWrite, memWrite}, 2'b00);
`endif

    // async reset during R_WB
    op_code = 6'b000000;
    memReady = 1'b1;
    tick();
    tick();
    tick();
    chk("rwb_state", state, 4'd7);
    chk("rwb_regWrite", regWrite, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", state, 4'd0);
    chk("arst_regWrite", regWrite, 0);
    chk("arst_memWrite", memWrite, 0);
    tick();
    chk("arst_hold", state, 4'd0);
    reset = 1'b0;
    tick();
    chk("arst_resume", state, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
